// File: rtl/ec_carry_resolver_if.sv
// ---------------------------------------------------------------------------
// ec_carry_resolver_if
// Handshake bundle between the carry resolver and its neighbours.
//   in_valid / in_ready / in_data[8:0] : pre-byte stream {carry, byte} from the
//                                        low-renormalisation stage
//   flush / flush_done                 : end-of-frame drain request and its
//                                        completion pulse
//   out_valid / out_ready / out_byte / : final bitstream bytes leaving the
//   out_last                             output FIFO
// Modports:
//   master : the side that produces pre-bytes and consumes output bytes
//   slave  : the resolver itself
// ---------------------------------------------------------------------------
interface ec_carry_resolver_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       flush_done;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_byte, out_last, flush_done
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_byte, out_last, flush_done
  );
endinterface

// File: rtl/ec_carry_resolver.sv
// ---------------------------------------------------------------------------
// ec_carry_resolver
// Sits after the range/low encoder core and turns 9-bit pre-bytes
// {carry, byte} into final bitstream bytes. One byte is held back as
// "pending" together with a count of deferred 0xFF bytes, because a later
// carry may still ripple into them. Resolved bytes leave through a small
// FIFO with a valid/ready handshake; a flush drains the tail of the frame.
//
// Ports:
//   general_clk  in   clock, all state on rising edge
//   reset        in   synchronous, active-high
//   bus          slave modport of ec_carry_resolver_if (pre-byte input,
//                flush request, output byte stream, flush_done pulse)
//   ff_overflow  out  sticky flag: deferred 0xFF run counter saturated
//   byte_count   out  [31:0] bytes popped by the consumer; present only when
//                     EC_BYTE_COUNT_EN is defined
//
// Parameters:
//   FF_CNT_WIDTH  width of the deferred-0xFF run counter
//   FIFO_AW       log2 of the output FIFO depth
//
// Optional feature macro: EC_BYTE_COUNT_EN
// ---------------------------------------------------------------------------
module ec_carry_resolver #(
  parameter int FF_CNT_WIDTH = 8,
  parameter int FIFO_AW      = 2
) (
  input  logic               general_clk,
  input  logic               reset,
  ec_carry_resolver_if.slave bus,
  output logic               ff_overflow
`ifdef EC_BYTE_COUNT_EN
  ,
  output logic [31:0]        byte_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_PEND,
    EMIT_RUN
  } state_t;

  localparam int                       DEPTH   = 1 << FIFO_AW;
  localparam logic [FF_CNT_WIDTH-1:0]  RUN_MAX = '1;
  localparam logic [FF_CNT_WIDTH-1:0]  RUN_ONE = FF_CNT_WIDTH'(1);

  state_t                  state;
  state_t                  state_next;

  logic                    have_pend;
  logic [7:0]              pend;
  logic [FF_CNT_WIDTH-1:0] run_cnt;
  logic [FF_CNT_WIDTH-1:0] run_left;
  logic [7:0]              emit_byte;
  logic [7:0]              run_byte;
  logic                    emit_last;
  logic                    flush_req;
  logic                    flush_done_q;

  logic [8:0]              fifo_mem [DEPTH];
  logic [FIFO_AW:0]        wr_ptr;
  logic [FIFO_AW:0]        rd_ptr;
  logic [8:0]              fifo_head;
  logic                    fifo_empty;
  logic                    fifo_full;

  logic                    in_ready_int;
  logic                    accept;
  logic                    in_c;
  logic [7:0]              in_b;
  logic                    is_ff;
  logic                    pop;
  logic                    push_ok;
  logic                    push;
  logic [8:0]              push_data;
  logic                    load_emit;
  logic                    load_flush;
  logic                    empty_flush;
  logic                    dec_run;

  assign in_c  = bus.in_data[8];
  assign in_b  = bus.in_data[7:0];
  // A carry-free 0xFF may still be turned into 0x00 by a later carry, so it
  // is only counted, never emitted directly.
  assign is_ff = !in_c && (in_b == 8'hFF);

  assign in_ready_int = (state == IDLE) && !flush_req;
  assign accept       = bus.in_valid && in_ready_int;

  // FIFO status: pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];
  assign pop        = !fifo_empty && bus.out_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign push_ok    = !fifo_full || pop;

  // State register.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the strobes that steer the datapath and the FIFO.
  always_comb begin
    state_next  = state;
    push        = 1'b0;
    push_data   = 9'h000;
    load_emit   = 1'b0;
    load_flush  = 1'b0;
    empty_flush = 1'b0;
    dec_run     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (have_pend && !is_ff) begin
            load_emit  = 1'b1;
            state_next = EMIT_PEND;
          end
        end else if (flush_req) begin
          if (have_pend) begin
            load_flush = 1'b1;
            state_next = EMIT_PEND;
          end else begin
            empty_flush = 1'b1;
          end
        end
      end
      EMIT_PEND: begin
        if (push_ok) begin
          push       = 1'b1;
          // On a flush with no deferred run, the pending byte ends the frame.
          push_data  = {emit_last && (run_left == '0), emit_byte};
          state_next = (run_left != '0) ? EMIT_RUN : IDLE;
        end
      end
      EMIT_RUN: begin
        if (push_ok) begin
          push      = 1'b1;
          push_data = {emit_last && (run_left == RUN_ONE), run_byte};
          dec_run   = 1'b1;
          if (run_left == RUN_ONE) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pending byte, deferred run and the byte/run staged for emission.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      have_pend   <= 1'b0;
      pend        <= 8'h00;
      run_cnt     <= '0;
      run_left    <= '0;
      emit_byte   <= 8'h00;
      run_byte    <= 8'h00;
      emit_last   <= 1'b0;
      ff_overflow <= 1'b0;
    end else begin
      if (accept) begin
        if (!have_pend) begin
          // The very first byte has no earlier byte to carry into.
          pend      <= in_b;
          have_pend <= 1'b1;
        end else if (is_ff) begin
          if (run_cnt == RUN_MAX) begin
            ff_overflow <= 1'b1;
          end else begin
            run_cnt <= run_cnt + RUN_ONE;
          end
        end else begin
          // The carry resolves the whole deferred run: 0xFF+1 wraps to 0x00.
          emit_byte <= pend + {7'd0, in_c};
          run_byte  <= in_c ? 8'h00 : 8'hFF;
          run_left  <= run_cnt;
          pend      <= in_b;
          run_cnt   <= '0;
          emit_last <= 1'b0;
        end
      end else if (load_flush) begin
        emit_byte <= pend;
        run_byte  <= 8'hFF;
        run_left  <= run_cnt;
        emit_last <= 1'b1;
        have_pend <= 1'b0;
        run_cnt   <= '0;
      end
      if (dec_run) begin
        run_left <= run_left - RUN_ONE;
      end
    end
  end

  // Flush bookkeeping. A new flush pulse wins over the clear of the old one.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      flush_req    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        flush_req <= 1'b1;
      end else if (load_flush || empty_flush) begin
        flush_req <= 1'b0;
      end
      flush_done_q <= empty_flush || (push && push_data[8]);
    end
  end

  // FIFO pointers.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge general_clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
    end
  end

`ifdef EC_BYTE_COUNT_EN
  // Counts consumed bytes across frames; only reset clears it.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      byte_count <= 32'd0;
    end else if (pop) begin
      byte_count <= byte_count + 32'd1;
    end
  end
`endif

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = !fifo_empty;
  // Empty FIFO shows zeros rather than stale storage.
  assign bus.out_byte   = fifo_empty ? 8'h00 : fifo_head[7:0];
  assign bus.out_last   = fifo_empty ? 1'b0 : fifo_head[8];
  assign bus.flush_done = flush_done_q;

endmodule
